// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control/status bundle between pipeline and PC sequencer
// Ports (slave = sequencer side):
//   inputs : stall, exc, branch, branch_cond, alu_flag, branch_target,
//            jump, call, jump_target, ret
//   outputs: pc, next_pc, redirect, ras_empty, ras_ovf, ras_unf
interface pc_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int FLAG_W = 4
);
  logic              stall;
  logic              exc;
  logic              branch;
  logic [FLAG_W-1:0] branch_cond;
  logic [FLAG_W-1:0] alu_flag;
  logic [ADDR_W-1:0] branch_target;
  logic              jump;
  logic              call;
  logic [ADDR_W-1:0] jump_target;
  logic              ret;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic              redirect;
  logic              ras_empty;
  logic              ras_ovf;
  logic              ras_unf;

  modport master (
    output stall, exc, branch, branch_cond, alu_flag, branch_target,
           jump, call, jump_target, ret,
    input  pc, next_pc, redirect, ras_empty, ras_ovf, ras_unf
  );

  modport slave (
    input  stall, exc, branch, branch_cond, alu_flag, branch_target,
           jump, call, jump_target, ret,
    output pc, next_pc, redirect, ras_empty, ras_ovf, ras_unf
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with return-address stack
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : pc_sequencer_if.slave (redirect requests in; pc, next_pc,
//           redirect and RAS status out)
module pc_sequencer #(
  parameter int                ADDR_W     = 32,
  parameter int                FLAG_W     = 4,
  parameter int                RAS_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = 'h80
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]     RAS_FULL = CW'(RAS_DEPTH);
  localparam logic [CW-1:0]     CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]     PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PC_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] next_pc_c;
  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  // ras_ptr is the next write slot; the top of stack sits just below it.
  logic [PW-1:0]     ras_ptr;
  logic [CW-1:0]     ras_cnt;
  logic              ovf_q;
  logic              unf_q;

  logic taken;
  logic ras_has;
  logic call_eff;
  logic live;
  logic do_push;
  logic do_pop;
  logic unf_set;

  always_comb begin
    pc_inc   = pc_q + PC_ONE;
    ras_top  = ras_mem[ras_ptr - PTR_ONE];
    ras_has  = (ras_cnt != '0);
    taken    = bus.branch && (bus.alu_flag == bus.branch_cond);
    // A call issued together with ret is dropped entirely, even when the
    // ret itself falls through on an empty stack.
    call_eff = bus.call && !bus.ret;
    live     = !bus.stall && !bus.exc;

    next_pc_c = pc_inc;
    if (bus.exc)                  next_pc_c = EXC_VECTOR;
    else if (bus.stall)           next_pc_c = pc_q;
    else if (bus.ret && ras_has)  next_pc_c = ras_top;
    else if (taken)               next_pc_c = bus.branch_target;
    else if (bus.jump || call_eff) next_pc_c = bus.jump_target;

    do_pop  = live && bus.ret && ras_has;
    unf_set = live && bus.ret && !ras_has;
    // Push only when the call actually won: no ret, no taken branch above it.
    do_push = live && call_eff && !taken;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_ADDR;
      ras_ptr <= '0;
      ras_cnt <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q <= next_pc_c;
      if (do_push) begin
        ras_ptr <= ras_ptr + PTR_ONE;
        // When full, the write slot already holds the oldest entry, so the
        // pointer advance alone makes the overwrite circular.
        if (ras_cnt == RAS_FULL) ovf_q   <= 1'b1;
        else                     ras_cnt <= ras_cnt + CNT_ONE;
      end
      if (do_pop) begin
        ras_ptr <= ras_ptr - PTR_ONE;
        ras_cnt <= ras_cnt - CNT_ONE;
      end
      if (unf_set) unf_q <= 1'b1;
    end
  end

  // Entry storage is not reset; contents are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (!reset && do_push) ras_mem[ras_ptr] <= pc_inc;
  end

  assign bus.pc        = pc_q;
  assign bus.next_pc   = next_pc_c;
  assign bus.redirect  = !bus.stall && (next_pc_c != pc_inc);
  assign bus.ras_empty = (ras_cnt == '0);
  assign bus.ras_ovf   = ovf_q;
  assign bus.ras_unf   = unf_q;
endmodule
